// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B - BI, one bit per clock, LSB first.
// Result and flags are registered and only updated at the completion edge.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             BI,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] D,
   output logic             BO,
   output logic             Z,
   output logic             OVF
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic IDLE  = 1'b0;
   localparam logic SHIFT = 1'b1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   // Full-subtractor cell: returns {borrow_out, difference}.
   function automatic logic [1:0] fs_cell(input logic a, input logic b, input logic bin);
      logic diff;
      logic bout;
      diff = a ^ b ^ bin;
      bout = (~a & b) | (~(a ^ b) & bin);
      return {bout, diff};
   endfunction

   logic             state_r;
   logic [WIDTH-1:0] sa_r;
   logic [WIDTH-1:0] sb_r;
   logic [WIDTH-1:0] res_r;
   logic             br_r;
   logic [CW-1:0]    cnt_r;
   logic             a_msb_r;
   logic             b_msb_r;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] d_r;
   logic             bo_r;
   logic             z_r;
   logic             ovf_r;

   logic [1:0]       cell_s;
   logic [WIDTH-1:0] res_next_s;
   logic             ovf_next_s;

   // Datapath for the current bit and the would-be final result.
   always_comb begin
      cell_s     = fs_cell(sa_r[0], sb_r[0], br_r);
      res_next_s = {cell_s[0], res_r[WIDTH-1:1]};
      ovf_next_s = (a_msb_r != b_msb_r) && (res_next_s[WIDTH-1] != a_msb_r);
   end

   // Control FSM, shift registers and registered result/flags.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= IDLE;
         sa_r    <= {WIDTH{1'b0}};
         sb_r    <= {WIDTH{1'b0}};
         res_r   <= {WIDTH{1'b0}};
         br_r    <= 1'b0;
         cnt_r   <= {CW{1'b0}};
         a_msb_r <= 1'b0;
         b_msb_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         d_r     <= {WIDTH{1'b0}};
         bo_r    <= 1'b0;
         z_r     <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (START) begin
                  sa_r    <= A;
                  sb_r    <= B;
                  br_r    <= BI;
                  res_r   <= {WIDTH{1'b0}};
                  cnt_r   <= {CW{1'b0}};
                  a_msb_r <= A[WIDTH-1];
                  b_msb_r <= B[WIDTH-1];
                  busy_r  <= 1'b1;
                  state_r <= SHIFT;
               end
            end
            SHIFT: begin
               sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
               sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
               res_r <= res_next_s;
               br_r  <= cell_s[1];
               cnt_r <= cnt_r + CW'(1);
               if (cnt_r == LAST_BIT) begin
                  d_r     <= res_next_s;
                  bo_r    <= cell_s[1];
                  z_r     <= (res_next_s == {WIDTH{1'b0}});
                  ovf_r   <= ovf_next_s;
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign BUSY = busy_r;
   assign DONE = done_r;
   assign D    = d_r;
   assign BO   = bo_r;
   assign Z    = z_r;
   assign OVF  = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         START = 1'b0;
   logic [W-1:0] A = 8'h00;
   logic [W-1:0] B = 8'h00;
   logic         BI = 1'b0;
   logic         BUSY;
   logic         DONE;
   logic [W-1:0] D;
   logic         BO;
   logic         Z;
   logic         OVF;

   int total = 0;
   int bad   = 0;
   int lat;
   logic [W-1:0] prev_d = 8'h00;
   logic         prev_bo = 1'b0;

   serial_subtractor #(.WIDTH(W)) dut (
      .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .BI(BI),
      .BUSY(BUSY), .DONE(DONE), .D(D), .BO(BO), .Z(Z), .OVF(OVF)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Reference: plain integer arithmetic on the operands.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        output logic [W-1:0] d, output logic bo, output logic z, output logic ovf);
      int diff;
      diff = int'(a) - int'(b) - int'(bi);
      d    = diff[W-1:0];
      bo   = (int'(a) < int'(b) + int'(bi));
      z    = (d == 8'h00);
      ovf  = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
   endtask

   // Present an operation and let the accepting edge pass.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      START = 1'b1; A = a; B = b; BI = bi;
      tick();
      START = 1'b0; A = W'($urandom); B = W'($urandom); BI = 1'($urandom);
      lat = 0;
      check("busy_after_accept", BUSY, 1'b1);
   endtask

   // Wait for DONE; meanwhile outputs must hold and BUSY must stay high.
   task automatic wait_done();
      while (!DONE && lat < 20) begin
         tick();
         lat++;
         if (!DONE) begin
            check("busy_hold", BUSY, 1'b1);
            check("d_hold", D, prev_d);
         end
      end
      check("done_seen", DONE, 1'b1);
      check("latency", lat, W);
   endtask

   task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      logic [W-1:0] ed;
      logic eb, ez, eo;
      model(a, b, bi, ed, eb, ez, eo);
      check({tag, "_d"}, D, ed);
      check({tag, "_bo"}, BO, eb);
      check({tag, "_z"}, Z, ez);
      check({tag, "_ovf"}, OVF, eo);
      check({tag, "_busy"}, BUSY, 1'b0);
      prev_d  = ed;
      prev_bo = eb;
   endtask

   task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      issue(a, b, bi);
      wait_done();
      check_result(tag, a, b, bi);
   endtask

   initial begin
      int seen;
      logic [W-1:0] ra, rb;
      logic rbi;

      repeat (2) tick();
      RST = 1'b0;
      check("rst_busy", BUSY, 1'b0);
      check("rst_done", DONE, 1'b0);
      check("rst_d", D, 8'h00);
      check("rst_flags", {BO, Z, OVF}, 3'b000);
      tick();

      run("t1", 8'h05, 8'h03, 1'b0);
      tick();
      check("done_one_cycle", DONE, 1'b0);
      check("d_after_done", D, 8'h02);
      run("t2", 8'h03, 8'h05, 1'b0);
      tick();
      run("t3", 8'h42, 8'h42, 1'b0);
      tick();
      run("t4", 8'h80, 8'h01, 1'b0);
      tick();
      run("t5", 8'h7F, 8'hFF, 1'b0);
      tick();
      run("t6", 8'h00, 8'h00, 1'b1);
      tick();

      // START during BUSY must be ignored.
      issue(8'h10, 8'h01, 1'b0);
      repeat (2) begin tick(); lat++; end
      START = 1'b1; A = 8'hAA; B = 8'h55;
      tick(); lat++;
      START = 1'b0;
      check("ignored_busy", BUSY, 1'b1);
      wait_done();
      check_result("ign", 8'h10, 8'h01, 1'b0);

      // START in the DONE cycle is accepted.
      issue(8'h09, 8'h04, 1'b0);
      check("b2b_done_low", DONE, 1'b0);
      wait_done();
      check_result("b2b", 8'h09, 8'h04, 1'b0);
      tick();

      // Reset mid-operation aborts it.
      issue(8'h33, 8'h11, 1'b0);
      repeat (3) tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("abort_busy", BUSY, 1'b0);
      check("abort_done", DONE, 1'b0);
      check("abort_d", D, 8'h00);
      check("abort_flags", {BO, Z, OVF}, 3'b000);
      seen = 0;
      repeat (12) begin
         tick();
         if (DONE) seen++;
      end
      check("abort_no_done", seen, 0);
      prev_d = 8'h00;
      run("fresh", 8'hC8, 8'h37, 1'b1);
      tick();

      // Random operands, sometimes back-to-back.
      for (int i = 0; i < 40; i++) begin
         ra  = W'($urandom);
         rb  = W'($urandom);
         rbi = 1'($urandom);
         run("rnd", ra, rb, rbi);
         if ($urandom_range(0, 1) == 0) tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
